// File: rtl/medidor_periodo_if.sv
// Signal bundle of medidor_periodo: slow input and restart toward the meter,
// per-edge tick, captured period, range flags and lock back from it.
interface medidor_periodo_if #(
  parameter int CNT_W = 28
);
  logic             sig_in;
  logic             clear;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             too_fast;
  logic             too_slow;
  logic             lock;
  logic [CNT_W-1:0] high_time;

  modport master (
    output sig_in, clear,
    input  tick, period, period_valid, too_fast, too_slow, lock, high_time
  );

  modport slave (
    input  sig_in, clear,
    output tick, period, period_valid, too_fast, too_slow, lock, high_time
  );
endinterface

// File: rtl/medidor_periodo.sv
// Period meter for a slow asynchronous input: synchronizes sig_in, pulses tick per rising edge,
// measures the period in clk cycles, flags out-of-range periods and reports lock.
// Define MEDIDOR_PERIODO_DUTY_EN to also measure the high time of each period on high_time.
module medidor_periodo #(
  parameter int CNT_W       = 28,
  parameter int PERIOD_MIN  = 2,
  parameter int PERIOD_MAX  = 100000000,
  parameter int LOCK_COUNT  = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              reset,
  medidor_periodo_if.slave bus
);
  localparam int               RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [RUN_W-1:0] LOCK_C = RUN_W'(LOCK_COUNT);

  typedef enum logic [1:0] {WAIT_FIRST, MEASURE, LOCKED, LOST} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   sync_out;
  logic                   rise;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [RUN_W-1:0] run, run_d;
  logic             tick_q, tick_d;
  logic             valid_q, valid_d;
  logic             too_fast_q, too_fast_d;
  logic             too_slow_q, too_slow_d;
  logic             lock_q, lock_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.sig_in};
      hist <= sync_out;
    end
  end

  assign sync_out = sync[SYNC_STAGES-1];
  assign rise     = sync_out & ~hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_FIRST;
      cnt        <= '0;
      period_q   <= '0;
      run        <= '0;
      tick_q     <= 1'b0;
      valid_q    <= 1'b0;
      too_fast_q <= 1'b0;
      too_slow_q <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      period_q   <= period_d;
      run        <= run_d;
      tick_q     <= tick_d;
      valid_q    <= valid_d;
      too_fast_q <= too_fast_d;
      too_slow_q <= too_slow_d;
      lock_q     <= lock_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first so no path through this block infers a latch.
    state_d    = state;
    cnt_d      = cnt;
    period_d   = period_q;
    run_d      = run;
    tick_d     = 1'b0;
    valid_d    = 1'b0;
    too_fast_d = too_fast_q;
    too_slow_d = too_slow_q;
    lock_d     = lock_q;

    if (bus.clear) begin
      // Restart wins over a coincident edge: no tick and the next edge is a first edge.
      state_d    = WAIT_FIRST;
      cnt_d      = '0;
      period_d   = '0;
      run_d      = '0;
      too_fast_d = 1'b0;
      too_slow_d = 1'b0;
      lock_d     = 1'b0;
    end else begin
      tick_d = rise;
      case (state)
        WAIT_FIRST, LOST: begin
          cnt_d = '0;
          if (rise) begin
            state_d    = MEASURE;
            cnt_d      = ONE_C;
            too_slow_d = 1'b0;
          end
        end
        default: begin
          if (rise) begin
            cnt_d    = ONE_C;
            period_d = cnt;
            valid_d  = 1'b1;
            if (cnt < MIN_C) begin
              too_fast_d = 1'b1;
              lock_d     = 1'b0;
              run_d      = '0;
              state_d    = MEASURE;
            end else begin
              too_fast_d = 1'b0;
              if (run != LOCK_C) run_d = run + RUN_W'(1);
              if (run_d == LOCK_C) begin
                lock_d  = 1'b1;
                state_d = LOCKED;
              end
            end
          end else if (cnt == MAX_C) begin
            // Timeout fires before cnt can exceed PERIOD_MAX, so cnt never wraps.
            state_d    = LOST;
            cnt_d      = '0;
            too_slow_d = 1'b1;
            lock_d     = 1'b0;
            run_d      = '0;
          end else begin
            cnt_d = cnt + ONE_C;
          end
        end
      endcase
    end
  end

  assign bus.tick         = tick_q;
  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.too_fast     = too_fast_q;
  assign bus.too_slow     = too_slow_q;
  assign bus.lock         = lock_q;

`ifdef MEDIDOR_PERIODO_DUTY_EN
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] high_time_q;
  logic             high_open;
  logic             fall;

  assign fall = ~sync_out & hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt        <= '0;
      high_time_q <= '0;
      high_open   <= 1'b0;
    end else if (bus.clear) begin
      hcnt        <= '0;
      high_time_q <= '0;
      high_open   <= 1'b0;
    end else if (rise) begin
      // A period with no falling edge was high throughout.
      if (high_open && valid_d) high_time_q <= period_d;
      hcnt      <= ONE_C;
      high_open <= 1'b1;
    end else if (high_open) begin
      if (fall) begin
        high_time_q <= hcnt;
        high_open   <= 1'b0;
      end else if (hcnt != MAX_C) begin
        hcnt <= hcnt + ONE_C;
      end
    end
  end

  assign bus.high_time = high_time_q;
`else
  assign bus.high_time = '0;
`endif

endmodule

// File: tb/tb_medidor_periodo.sv
// Self-checking bench for medidor_periodo: directed table of waveforms, hand-written corner
// sequences and random periods, all compared every cycle against a timestamp-based model.
module tb_medidor_periodo;
  localparam int CNT_W = 8;
  localparam int P_MIN = 8;
  localparam int P_MAX = 12;
  localparam int LC    = 3;
  localparam int SS    = 2;
`ifdef MEDIDOR_PERIODO_DUTY_EN
  localparam int EXP_HIGH = 4;
`else
  localparam int EXP_HIGH = 0;
`endif

  logic clk;
  logic reset;

  medidor_periodo_if #(.CNT_W(CNT_W)) bus ();

  medidor_periodo #(
    .CNT_W(CNT_W), .PERIOD_MIN(P_MIN), .PERIOD_MAX(P_MAX),
    .LOCK_COUNT(LC), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: sampled-input history plus the timestamp of the last counted edge.
  bit drv_q[$];
  int cyc;
  bit have_ref;
  int last_edge;
  int run_len;
  int m_period;
  bit m_tick, m_valid, m_fast, m_slow, m_lock;

  typedef struct {
    int per;
    int hi;
    int n;
    int exp_period;
    bit exp_fast;
    bit exp_slow;
    bit exp_lock;
  } row_t;

  row_t rows[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    drv_q.delete();
    repeat (SS + 2) drv_q.push_back(1'b0);
    have_ref  = 1'b0;
    last_edge = 0;
    run_len   = 0;
    m_period  = 0;
    m_tick    = 1'b0;
    m_valid   = 1'b0;
    m_fast    = 1'b0;
    m_slow    = 1'b0;
    m_lock    = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit c);
    bit edge_now;
    int d;
    cyc++;
    drv_q.push_front(s);
    if (drv_q.size() > SS + 2) void'(drv_q.pop_back());
    // An input rise sampled at edge n becomes a counted edge at edge n+SS.
    edge_now = drv_q[SS] && !drv_q[SS+1];
    m_tick   = 1'b0;
    m_valid  = 1'b0;
    if (c) begin
      have_ref = 1'b0;
      run_len  = 0;
      m_period = 0;
      m_fast   = 1'b0;
      m_slow   = 1'b0;
    end else begin
      m_tick = edge_now;
      if (have_ref) begin
        d = cyc - last_edge;
        if (edge_now) begin
          m_period  = d;
          m_valid   = 1'b1;
          last_edge = cyc;
          if (d < P_MIN) begin
            m_fast  = 1'b1;
            run_len = 0;
          end else begin
            m_fast = 1'b0;
            if (run_len < LC) run_len++;
          end
        end else if (d == P_MAX) begin
          have_ref = 1'b0;
          m_slow   = 1'b1;
          run_len  = 0;
        end
      end else if (edge_now) begin
        have_ref  = 1'b1;
        last_edge = cyc;
        m_slow    = 1'b0;
      end
    end
    m_lock = (run_len == LC);
  endtask

  task automatic cycle(input logic s, input logic c);
    bus.sig_in = s;
    bus.clear  = c;
    @(posedge clk);
    model_step(s, c);
    @(negedge clk);
    check("tick", 32'(bus.tick), 32'(m_tick));
    check("period", 32'(bus.period), m_period);
    check("period_valid", 32'(bus.period_valid), 32'(m_valid));
    check("too_fast", 32'(bus.too_fast), 32'(m_fast));
    check("too_slow", 32'(bus.too_slow), 32'(m_slow));
    check("lock", 32'(bus.lock), 32'(m_lock));
`ifndef MEDIDOR_PERIODO_DUTY_EN
    check("high_time_zero", 32'(bus.high_time), 0);
`endif
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < per; j++)
        cycle(j < hi, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"}, 32'(bus.tick), 0);
    check({tag, "_period"}, 32'(bus.period), 0);
    check({tag, "_valid"}, 32'(bus.period_valid), 0);
    check({tag, "_fast"}, 32'(bus.too_fast), 0);
    check({tag, "_slow"}, 32'(bus.too_slow), 0);
    check({tag, "_lock"}, 32'(bus.lock), 0);
    check({tag, "_high"}, 32'(bus.high_time), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int p, h;
    rows[0] = '{10, 5, 6, 10, 1'b0, 1'b0, 1'b1};  // lock after the 4th edge
    rows[1] = '{ 5, 2, 1, 10, 1'b0, 1'b0, 1'b1};  // short period, captured at the next row
    rows[2] = '{10, 5, 3, 10, 1'b0, 1'b0, 1'b0};  // 5 flagged fast, run restarts
    rows[3] = '{ 8, 4, 2,  8, 1'b0, 1'b0, 1'b1};  // lower boundary in range
    rows[4] = '{12, 6, 2, 12, 1'b0, 1'b0, 1'b1};  // upper boundary in range
    rows[5] = '{20, 0, 1, 12, 1'b0, 1'b1, 1'b0};  // input stops: timeout
    rows[6] = '{10, 5, 2, 10, 1'b0, 1'b0, 1'b0};  // recovery edge is a first edge

    cyc        = 0;
    reset      = 1'b0;
    bus.sig_in = 1'b1;
    bus.clear  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    bus.sig_in = 1'b0;
    reset      = 1'b1;

    for (int r = 0; r < 7; r++) begin
      wave(rows[r].per, rows[r].hi, rows[r].n);
      check($sformatf("row%0d_period", r), 32'(bus.period), rows[r].exp_period);
      check($sformatf("row%0d_fast", r), 32'(bus.too_fast), 32'(rows[r].exp_fast));
      check($sformatf("row%0d_slow", r), 32'(bus.too_slow), 32'(rows[r].exp_slow));
      check($sformatf("row%0d_lock", r), 32'(bus.lock), 32'(rows[r].exp_lock));
    end

    // Tick latency counted in clk edges, the sampling edge being the first.
    repeat (3) cycle(1'b0, 1'b0);
    lat = 1;
    cycle(1'b1, 1'b0);
    while (!bus.tick && lat < 10) begin
      cycle(1'b1, 1'b0);
      lat++;
    end
    check("tick_latency", lat, SS + 1);

    // Clear coincident with an edge while locked.
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    wave(10, 5, 5);
    check("pre_clear_lock", 32'(bus.lock), 1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    check("clear_edge_tick", 32'(bus.tick), 0);
    check("clear_edge_lock", 32'(bus.lock), 0);
    check("clear_edge_period", 32'(bus.period), 0);
    repeat (2) cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0);
    check("post_clear_tick", 32'(bus.tick), 1);
    check("post_clear_valid", 32'(bus.period_valid), 0);
    check("post_clear_period", 32'(bus.period), 0);

    // Asynchronous reset in the middle of a count.
    repeat (2) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    wave(10, 5, 5);
    check("pre_reset_lock", 32'(bus.lock), 1);
    check("pre_reset_period", 32'(bus.period), 10);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    bus.sig_in = 1'b0;
    @(negedge clk);
    model_reset();
    reset = 1'b1;

    repeat (3) cycle(1'b0, 1'b0);
    wave(10, 4, 3);
    check("high_time", 32'(bus.high_time), EXP_HIGH);

    for (int i = 0; i < 300; i++) begin
      p = $urandom_range(15, 5);
      h = $urandom_range(p - 1, 1);
      for (int j = 0; j < p; j++) cycle(j < h, $urandom_range(99, 0) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/medidor_periodo.md
Name: medidor_periodo

Overview:
- Receive-side companion of the cascaded clock divider: takes a slow divided clock or external slow pulse `sig_in` back into the fast `clk` domain.
- Synchronizes `sig_in`, detects its rising edges, emits a one-cycle `tick` per edge and measures the period in `clk` cycles.
- Flags periods outside [PERIOD_MIN, PERIOD_MAX] and asserts `lock` once the period is stable.
- Used as a clock-enable source and as a self-check for the divider chain.

Parameters:
- CNT_W, 28: width of the period counter and `period`. PERIOD_MAX < 2^CNT_W - 1 is required.
- PERIOD_MIN, 2: minimum legal period in `clk` cycles, inclusive.
- PERIOD_MAX, 100000000: maximum legal period in `clk` cycles, inclusive; also the timeout.
- LOCK_COUNT, 4: number of consecutive in-range periods required to assert `lock` (≥1).
- SYNC_STAGES, 2: flip-flops in the `sig_in` synchronizer (≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sig_in  in  1  asynchronous slow input, for example a divider output.
- clear  in  1  synchronous restart of the measurement.
- tick  out  1  one-cycle pulse per detected rising edge of `sig_in`.
- period  out  CNT_W  last captured period; holds until the next capture.
- period_valid  out  1  one-cycle pulse when `period` updates.
- too_fast  out  1  last captured period was < PERIOD_MIN.
- too_slow  out  1  timeout: no edge within PERIOD_MAX cycles.
- lock  out  1  stable in-range period.
- high_time  out  CNT_W  see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to WAIT_FIRST.
  - Synchronizer, edge register, counter and `period` go to 0.
  - All outputs go to 0.
  - Reset asserted mid-measurement discards everything.
- Synchronizer: `sig_in` passes through SYNC_STAGES flops, then one history flop.
- Edge detection:
  - edge = sync_out & ~history.
  - `tick` is registered and high for exactly one cycle.
  - `tick` rises SYNC_STAGES+1 `clk` rising edges after the first edge that samples `sig_in`=1.
  - Glitches shorter than one `clk` cycle may be missed; this is not an error.
- Counter `cnt`:
  - On an edge cycle, `cnt` <= 1; otherwise `cnt` <= `cnt`+1.
  - In WAIT_FIRST and LOST, `cnt` holds at 0.
  - `cnt` never wraps, because the timeout triggers first.
- FSM:
  - WAIT_FIRST: on an edge, go to MEASURE (`cnt`=1). No period is captured.
  - MEASURE and LOCKED, edge:
    - `period` <= `cnt`; `period_valid` pulses in the same cycle as `tick`.
    - If PERIOD_MIN ≤ `cnt` ≤ PERIOD_MAX: `too_fast` <= 0 and the in-range run counter increments, saturating at LOCK_COUNT.
    - Once the run counter reaches LOCK_COUNT: `lock` <= 1 and the state becomes LOCKED.
    - If `cnt` < PERIOD_MIN: `too_fast` <= 1, `lock` <= 0, run counter <= 0, state becomes MEASURE.
  - MEASURE and LOCKED, no edge with `cnt` == PERIOD_MAX:
    - Go to LOST; `too_slow` <= 1, `lock` <= 0, run counter <= 0.
    - An edge arriving exactly when `cnt` == PERIOD_MAX is in range; no timeout occurs.
  - LOST: on an edge, `too_slow` <= 0 and go to MEASURE. That edge is treated as a first edge, so no capture.
- `clear`:
  - Same effect as reset on the FSM, counter, flags, `lock` and `period`.
  - Synchronizer and history flops are unaffected.
  - If `clear` and an edge occur in the same cycle, `clear` wins: no `tick`, no capture, and the next edge is a first edge.
- `too_fast` and `too_slow` are levels, held until the clearing condition above.

Optional Feature:
- Macro: MEDIDOR_PERIODO_DUTY_EN.
- Defined:
  - A second counter measures synchronized-high cycles from an edge to the falling edge.
  - On the falling edge it latches to `high_time`.
  - If no falling edge occurs before the next rising edge, `high_time` <= `period`.
  - Reset and `clear` set `high_time` to 0.
- Undefined: `high_time` is tied to 0 and no extra logic is generated.

Test Plan:
Overrides for all scenarios: PERIOD_MIN=8, PERIOD_MAX=12, LOCK_COUNT=3, SYNC_STAGES=2.
- Square wave on `sig_in`, period 10 `clk`, for 6 edges:
  - `tick` ×6, each 3 cycles after the sampled rise.
  - No capture on edge 1; `period`=10 with `period_valid` on edges 2–6.
  - `lock`=1 after edge 4.
- Locked at 10, then one period of 5:
  - On that edge: `period`=5, `too_fast`=1, `lock`=0.
  - Three further periods of 10: `too_fast`=0 at the next edge, `lock`=1 after the 3rd.
- Boundaries, periods of 8 and 12: both in range; `too_fast`=`too_slow`=0.
- Stop `sig_in` after a lock:
  - `too_slow`=1 and `lock`=0 exactly when `cnt` hits 12 without an edge.
  - Next edge: `too_slow`=0 with no capture; the following edge captures.
- `clear` coincident with an edge while LOCKED: no `tick`; `lock`=0, `period`=0. The next edge produces no capture.
- With MEDIDOR_PERIODO_DUTY_EN: 10-cycle period, 4 cycles high → `high_time`=4.
- Without MEDIDOR_PERIODO_DUTY_EN: `high_time`=0 throughout.
- Drop reset mid-count: all outputs 0 immediately, without waiting for `clk`.
